// File: rtl/multicycle_step_counter.sv
// Programmable-limit step counter with start/busy/done handshake.
// One-shot mode pulses done after reaching the limit; wrap mode counts modulo limit+1.
module multicycle_step_counter #(
    parameter int CNT_WIDTH  = 6,
    parameter int WRAP_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  limit_i,
    input  logic                  mode_i,
    input  logic                  step_en_i,
    input  logic                  stop_i,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  cnt_end_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WRAP_WIDTH-1:0] wrap_cnt_o
);

    // state | meaning
    // IDLE  | no operation; waits for start
    // RUN   | counting steps toward the latched limit
    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam logic MODE_ONESHOT = 1'b1;

    logic                  state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  limit_q, limit_d;
    logic                  mode_q, mode_d;
    logic [WRAP_WIDTH-1:0] wrap_q, wrap_d;
    logic                  done_q, done_d;
    logic                  at_limit;

    assign at_limit = (cnt_q == limit_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            wrap_d  = '0;
        end else if ((state_q == S_RUN) && stop_i) begin
            // wrap tally is kept so the owner can read it after stopping
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_RUN;
                        limit_d = limit_i;
                        mode_d  = mode_i;
                        cnt_d   = '0;
                        wrap_d  = '0;
                    end
                end
                S_RUN: begin
                    if (step_en_i) begin
                        if (at_limit) begin
                            cnt_d = '0;
                            if (mode_q == MODE_ONESHOT) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else if (wrap_q != {WRAP_WIDTH{1'b1}}) begin
                                wrap_d = wrap_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign cnt_end_o  = busy_o && at_limit;
    assign cnt_o      = cnt_q;
    assign done_o     = done_q;
    assign wrap_cnt_o = wrap_q;

endmodule

// File: tb/tb_multicycle_step_counter.sv
// Directed bench for multicycle_step_counter; expected values are hand-derived.
module tb_multicycle_step_counter;

    logic       clk = 1'b0;
    logic       reset, flush, start, mode, step_en, stop;
    logic [5:0] limit;
    logic [5:0] cnt;
    logic       cnt_end, busy, done;
    logic [3:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    multicycle_step_counter #(.CNT_WIDTH(6), .WRAP_WIDTH(4)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .start_i    (start),
        .limit_i    (limit),
        .mode_i     (mode),
        .step_en_i  (step_en),
        .stop_i     (stop),
        .cnt_o      (cnt),
        .cnt_end_o  (cnt_end),
        .busy_o     (busy),
        .done_o     (done),
        .wrap_cnt_o (wrap_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_wrap, input logic exp_done);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt), 32'd0);
        chk({tag, "_cnt_end"}, 32'(cnt_end), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_wrap"}, 32'(wrap_cnt), 32'(exp_wrap));
    endtask

    initial begin
        logic       pat [5];
        logic [5:0] exp3 [5];
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp3 = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd2};

        reset = 1'b1; flush = 1'b0; start = 1'b0; mode = 1'b0;
        step_en = 1'b0; stop = 1'b0; limit = '0;
        tick(); tick();
        reset = 1'b0;
        chk_idle("reset", 4'd0, 1'b0);

        // one-shot, limit 39, continuous steps
        limit = 6'd39; mode = 1'b1; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk("os_busy", 32'(busy), 32'd1);
            chk("os_cnt", 32'(cnt), 32'(c - 1));
            chk("os_cnt_end", 32'(cnt_end), 32'(c == 40));
            chk("os_done_low", 32'(done), 32'd0);
            if (c == 40) step_en = 1'b1;
            tick();
        end
        step_en = 1'b0;
        chk_idle("os_complete", 4'd0, 1'b1);
        tick();
        chk("os_done_drop", 32'(done), 32'd0);

        // wrap, limit 3, ten stepping cycles then stop
        limit = 6'd3; mode = 1'b0; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 10; r++) begin
            chk("wr_cnt", 32'(cnt), 32'(r % 4));
            chk("wr_busy", 32'(busy), 32'd1);
            chk("wr_done", 32'(done), 32'd0);
            chk("wr_cnt_end", 32'(cnt_end), 32'((r % 4) == 3));
            if (r < 9) tick();
        end
        chk("wr_tally", 32'(wrap_cnt), 32'd2);
        step_en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("wr_stop", 4'd2, 1'b0);

        // gapped steps, limit 2 one-shot; mid-run start with limit 9 must not relatch
        limit = 6'd2; mode = 1'b1; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            step_en = pat[i];
            start   = (i >= 1);
            limit   = (i >= 1) ? 6'd9 : 6'd2;
            chk("gap_cnt", 32'(cnt), 32'(exp3[i]));
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_cnt_end", 32'(cnt_end), 32'(i == 4));
            tick();
        end
        step_en = 1'b0;
        chk_idle("gap_done", 4'd0, 1'b1);
        tick();
        start = 1'b0;
        chk("gap_restart_busy", 32'(busy), 32'd1);
        chk("gap_restart_cnt_end", 32'(cnt_end), 32'd0);
        chk("gap_restart_done", 32'(done), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("gap_flush", 4'd0, 1'b0);

        // flush at cnt 5 with coincident start
        limit = 6'd39; mode = 1'b1; step_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("fl_cnt5", 32'(cnt), 32'd5);
        flush = 1'b1; start = 1'b1; step_en = 1'b0;
        tick();
        flush = 1'b0; start = 1'b0;
        chk_idle("fl_abort", 4'd0, 1'b0);
        tick();
        chk("fl_no_new_op", 32'(busy), 32'd0);

        // limit 0, one-shot
        limit = 6'd0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("l0_busy", 32'(busy), 32'd1);
        chk("l0_cnt_end", 32'(cnt_end), 32'd1);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        chk_idle("l0_done", 4'd0, 1'b1);
        tick();
        chk("l0_done_drop", 32'(done), 32'd0);

        // limit 0, wrap: tally saturates at 15
        limit = 6'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("l0w_cnt_end", 32'(cnt_end), 32'd1);
        step_en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("l0w_tally", 32'(wrap_cnt), 32'((i > 15) ? 15 : i));
            chk("l0w_busy", 32'(busy), 32'd1);
        end
        step_en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("l0w_stop", 4'd15, 1'b0);

        // reset mid-run with coincident start
        limit = 6'd20; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; step_en = 1'b1;
        repeat (7) tick();
        chk("rst_cnt7", 32'(cnt), 32'd7);
        reset = 1'b1; start = 1'b1; step_en = 1'b0;
        tick();
        reset = 1'b0; start = 1'b0;
        chk_idle("rst_mid", 4'd0, 1'b0);
        tick();
        chk("rst_start_dropped", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_step_counter.md
Name: multicycle_step_counter

Overview:
- Programmable-limit step counter for multi-cycle execution units such as the iterative divider/multiplier and CSR sequencing.
- Replaces fixed-terminal-count counters with a start/busy/done handshake.
- Terminal count is loaded per operation; two modes: one-shot (count once, then report done) and wrap (free-running modulo limit+1, with a wrap tally).
- Sits beside the owning unit's FSM; flush comes from the pipeline redirect logic.

Parameters:
CNT_WIDTH, 6, width of count and limit.
WRAP_WIDTH, 4, width of wrap tally (saturating).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush; aborts operation
start  in  1  begin operation; sampled only when idle
limit  in  CNT_WIDTH  terminal count, latched at accepted start
mode  in  1  0=wrap, 1=one-shot; latched at accepted start
step_en  in  1  advance count this cycle
stop  in  1  end wrap-mode operation without done
cnt  out  CNT_WIDTH  current count
cnt_end  out  1  busy and cnt==latched limit (combinational)
busy  out  1  operation in progress
done  out  1  one-cycle pulse after one-shot completion (registered)
wrap_cnt  out  WRAP_WIDTH  completed wraps since last start, saturating

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset: state IDLE; cnt=0, limit_r=0, mode_r=0, wrap_cnt=0, done=0, busy=0, cnt_end=0.
- States: IDLE, RUN. busy = (state==RUN).
- Priority per cycle: reset > flush > stop > start/step.
- IDLE:
  - start=1 → limit_r<=limit, mode_r<=mode, cnt<=0, wrap_cnt<=0, go RUN. busy is high the next cycle.
  - step_en and stop are ignored.
- RUN, step_en=1, cnt!=limit_r: cnt<=cnt+1.
- RUN, step_en=1, cnt==limit_r:
  - One-shot: cnt<=0, go IDLE, done<=1 (visible the next cycle, for exactly one cycle).
  - Wrap: cnt<=0, stay RUN, wrap_cnt<=wrap_cnt+1, saturating at all-ones.
- RUN, step_en=0: cnt holds.
- start while RUN: ignored. Limit and mode are not re-latched. A start coincident with one-shot completion is ignored; it is accepted the following cycle (IDLE, done=1). start with done=1 in IDLE is legal.
- stop in RUN (either mode): cnt<=0, go IDLE, no done pulse; wrap_cnt holds until the next start.
- flush (any state): cnt<=0, go IDLE, done<=0, wrap_cnt<=0. A start in the same cycle is dropped.
- limit=0: cnt_end is high on the first RUN cycle.
  - One-shot completes on the first step_en.
  - Wrap mode increments wrap_cnt on every step_en.
- limit=all-ones: count spans the full 2^CNT_WIDTH range; no overflow beyond it.
- done is 0 in every cycle except the one following one-shot completion.
- cnt_end is never high in IDLE.
- Arithmetic: unsigned, CNT_WIDTH bits; the compare uses the latched limit_r, never the live limit input.

Test Plan:
- One-shot, limit=39, mode=1, step_en held high, start at cycle 0 → busy cycles 1..40, cnt 0..39, cnt_end only in cycle 40; cycle 41: busy=0, cnt=0, done=1; cycle 42: done=0.
- Wrap, limit=3, mode=0, step_en high for 10 RUN cycles → cnt 0,1,2,3,0,1,2,3,0,1; wrap_cnt=2; done never asserted; stop then → IDLE, cnt=0, wrap_cnt stays 2.
- Gapped steps, limit=2, one-shot, step_en pattern 1,0,0,1,1 → cnt 0,1,1,1,2, then done; start during RUN with limit=9 has no effect on latched limit.
- Flush at cnt=5 in one-shot limit=39 with start asserted same cycle → next cycle IDLE, cnt=0, done=0, no new operation.
- limit=0, one-shot: cnt_end=1 on first RUN cycle; one step_en → done pulse. Same in wrap mode with WRAP_WIDTH=4 and 20 steps → wrap_cnt saturates at 15.
- Reset asserted mid-RUN (cnt=7, wrap mode) → next cycle all outputs at reset values; a start in the same cycle as reset is ignored.
